// File: rtl/ex_mem_flag_reg.sv
// ex_mem_flag_reg: EX/MEM pipeline register plus Z/V/N processor flag register.
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   ex_valid .. ex_halt             execute-stage instruction, result and control
//   stall                           hold pipeline contents and flags
//   flush                           squash EX instruction, insert bubble (beats stall)
//   mem_valid .. mem_halt           registered copies of the EX fields
//   flag_z, flag_v, flag_n          registered zero / overflow / negative flags
module ex_mem_flag_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovfl,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_halt,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [3:0]        mem_opcode,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_wr,
    output logic              mem_mem_rd,
    output logic              mem_mem_wr,
    output logic [DATA_W-1:0] mem_store_data,
    output logic              mem_halt,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n
);
    logic set_zvn;
    logic set_z;
    logic load;

    always_comb begin
        load    = !flush && !stall;
        // ADD/SUB write all three flags; XOR and the shifts/rotate write only Z
        set_zvn = ex_valid && (ex_opcode == 4'b0000 || ex_opcode == 4'b0001);
        set_z   = set_zvn || (ex_valid && (ex_opcode == 4'b0010 || ex_opcode == 4'b0100 ||
                                           ex_opcode == 4'b0101 || ex_opcode == 4'b0110));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_opcode     <= '0;
            mem_result     <= '0;
            mem_rd         <= '0;
            mem_reg_wr     <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
            mem_halt       <= 1'b0;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_opcode     <= '0;
            mem_result     <= '0;
            mem_rd         <= '0;
            mem_reg_wr     <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
            mem_halt       <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_opcode     <= ex_opcode;
            mem_result     <= ex_result;
            mem_rd         <= ex_rd;
            // side-effecting controls of a bubble must never reach MEM/WB
            mem_reg_wr     <= ex_valid && ex_reg_wr;
            mem_mem_rd     <= ex_valid && ex_mem_rd;
            mem_mem_wr     <= ex_valid && ex_mem_wr;
            mem_store_data <= ex_store_data;
            mem_halt       <= ex_valid && ex_halt;
        end
    end

    // flags advance only on a load edge; a flush or stall leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (load) begin
            if (set_z)
                flag_z <= (ex_result == '0);
            if (set_zvn) begin
                flag_v <= ex_ovfl;
                flag_n <= ex_result[DATA_W-1];
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_flag_reg.sv
// tb_ex_mem_flag_reg: scoreboard-based self-checking bench for ex_mem_flag_reg.
module tb_ex_mem_flag_reg;
    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [15:0] result;
        logic [3:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [15:0] store_data;
        logic        halt;
        logic        fz;
        logic        fv;
        logic        fn;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_opcode = '0;
    logic [15:0] ex_result = '0;
    logic        ex_ovfl = 1'b0;
    logic [3:0]  ex_rd = '0;
    logic        ex_reg_wr = 1'b0;
    logic        ex_mem_rd = 1'b0;
    logic        ex_mem_wr = 1'b0;
    logic [15:0] ex_store_data = '0;
    logic        ex_halt = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic        mem_reg_wr;
    logic        mem_mem_rd;
    logic        mem_mem_wr;
    logic [15:0] mem_store_data;
    logic        mem_halt;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int   total = 0;
    int   bad = 0;
    out_t state = '0;
    out_t sb[$];
    out_t obs;

    ex_mem_flag_reg #(.DATA_W(16), .REG_AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovfl(ex_ovfl), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_store_data(ex_store_data), .ex_halt(ex_halt),
        .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_result(mem_result),
        .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_mem_rd(mem_mem_rd),
        .mem_mem_wr(mem_mem_wr), .mem_store_data(mem_store_data),
        .mem_halt(mem_halt), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    assign obs = '{mem_valid, mem_opcode, mem_result, mem_rd, mem_reg_wr, mem_mem_rd,
                   mem_mem_wr, mem_store_data, mem_halt, flag_z, flag_v, flag_n};

    function automatic out_t model(input out_t c);
        out_t r = c;
        if (flush) begin
            r = '0;
            r.fz = c.fz;
            r.fv = c.fv;
            r.fn = c.fn;
        end else if (!stall) begin
            r.valid      = ex_valid;
            r.opcode     = ex_opcode;
            r.result     = ex_result;
            r.rd         = ex_rd;
            r.reg_wr     = ex_valid & ex_reg_wr;
            r.mem_rd     = ex_valid & ex_mem_rd;
            r.mem_wr     = ex_valid & ex_mem_wr;
            r.store_data = ex_store_data;
            r.halt       = ex_valid & ex_halt;
            if (ex_valid) begin
                case (ex_opcode)
                    4'h0, 4'h1: begin
                        r.fz = (ex_result == 16'h0);
                        r.fv = ex_ovfl;
                        r.fn = ex_result[15];
                    end
                    4'h2, 4'h4, 4'h5, 4'h6: r.fz = (ex_result == 16'h0);
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic [3:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic [15:0] sd,
                         input logic h, input logic st, input logic fl);
        ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ov; ex_rd = rd;
        ex_reg_wr = rw; ex_mem_rd = mr; ex_mem_wr = mw; ex_store_data = sd;
        ex_halt = h; stall = st; flush = fl;
    endtask

    // push the expected post-edge state, clock once, pop and compare
    task automatic step(input string name);
        out_t e;
        state = model(state);
        sb.push_back(state);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, obs, e);
        end
    endtask

    task automatic test_reset();
        drive(1, 4'h7, 16'h1234, 1, 4'h5, 1, 1, 1, 16'hbeef, 1, 0, 0);
        step("reset_preload");
        drive(1, 4'hf, 16'hffff, 1, 4'hf, 1, 1, 1, 16'hffff, 1, 1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_async: got %h expected 0", obs);
        end
        state = '0;
        @(posedge clk);
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_hold: got %h expected 0", obs);
        end
        rst_n = 1'b1;
        drive(1, 4'h3, 16'h00a5, 0, 4'h2, 1, 0, 0, 16'h0011, 0, 0, 0);
        step("reset_first_load");
    endtask

    task automatic test_add();
        drive(1, 4'h0, 16'h8000, 1, 4'h3, 1, 0, 0, 16'h0000, 0, 0, 0);
        step("add_load");
        total++;
        if ({mem_result, mem_rd, mem_reg_wr, flag_n, flag_v, flag_z} !== {16'h8000, 4'h3, 4'b1110}) begin
            bad++;
            $display("FAIL add_fields: got %h expected 8000_3_e", {mem_result, mem_rd, mem_reg_wr, flag_n, flag_v, flag_z});
        end
    endtask

    task automatic test_z_only();
        drive(1, 4'h4, 16'h0000, 0, 4'h4, 1, 0, 0, 16'h0000, 0, 0, 0);
        step("sll_z_only");
        total++;
        if ({flag_z, flag_v, flag_n} !== 3'b111) begin
            bad++;
            $display("FAIL sll_flags: got %b expected 111", {flag_z, flag_v, flag_n});
        end
        drive(1, 4'h8, 16'h0000, 1, 4'h6, 1, 1, 0, 16'h0000, 0, 0, 0);
        step("lw_no_flags");
        drive(1, 4'h0, 16'h0001, 0, 4'h1, 1, 0, 0, 16'h0000, 0, 0, 0);
        step("add_clear");
        drive(1, 4'h2, 16'h0000, 1, 4'h1, 1, 0, 0, 16'h0000, 0, 0, 0);
        step("xor_zero");
        drive(1, 4'h7, 16'h8000, 1, 4'h1, 1, 0, 0, 16'h0000, 0, 0, 0);
        step("paddsb_no_flags");
    endtask

    task automatic test_stall();
        drive(1, 4'h1, 16'h0000, 1, 4'h9, 1, 0, 0, 16'h5555, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("stall_hold");
        stall = 1'b0;
        step("stall_release_sub");
        total++;
        if ({flag_z, flag_v, flag_n} !== 3'b110) begin
            bad++;
            $display("FAIL sub_flags: got %b expected 110", {flag_z, flag_v, flag_n});
        end
    endtask

    task automatic test_flush();
        drive(1, 4'h0, 16'h0000, 0, 4'h7, 1, 0, 1, 16'h1111, 1, 1, 1);
        step("flush_over_stall");
        drive(1, 4'h0, 16'h8000, 0, 4'h7, 1, 0, 1, 16'h1111, 1, 0, 1);
        step("flush_no_flags");
    endtask

    task automatic test_bubble();
        drive(0, 4'h0, 16'h0000, 1, 4'ha, 1, 1, 1, 16'h2222, 1, 0, 0);
        step("bubble_gating");
    endtask

    task automatic test_back_to_back();
        drive(1, 4'h0, 16'hf000, 1, 4'h1, 1, 0, 0, 16'h0000, 0, 0, 0);
        step("b2b_add");
        drive(1, 4'h4, 16'h0000, 0, 4'h2, 1, 0, 0, 16'h0000, 0, 0, 0);
        step("b2b_sll");
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            step("random");
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL power_on_reset: got %h expected 0", obs);
        end
        rst_n = 1'b1;
        test_reset();
        test_add();
        test_z_only();
        test_stall();
        test_flush();
        test_bubble();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_mem_flag_reg.md
Name: ex_mem_flag_reg

Overview:
- EX/MEM pipeline register plus the processor flag register (Z, V, N).
- Sits directly downstream of the execute stage (adder, shifter, XOR, RED, PADDSB muxed into one result).
- Captures the EX result and control each cycle and updates flags per ISA rules.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 16, datapath width of result and store data
- REG_AW, 4, register-file address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  4  EX instruction opcode
- ex_result  in  DATA_W  execute-stage result
- ex_ovfl  in  1  signed overflow from adder (ADD/SUB only)
- ex_rd  in  REG_AW  destination register
- ex_reg_wr  in  1  instruction writes register file
- ex_mem_rd  in  1  load
- ex_mem_wr  in  1  store
- ex_store_data  in  DATA_W  store data (rt value)
- ex_halt  in  1  HLT in EX
- stall  in  1  hold EX/MEM contents and flags
- flush  in  1  squash EX instruction, insert bubble
- mem_valid  out  1  registered valid
- mem_opcode  out  4  registered opcode
- mem_result  out  DATA_W  registered result
- mem_rd  out  REG_AW  registered destination
- mem_reg_wr  out  1  registered reg-write enable
- mem_mem_rd  out  1  registered load
- mem_mem_wr  out  1  registered store
- mem_store_data  out  DATA_W  registered store data
- mem_halt  out  1  registered halt
- flag_z  out  1  zero flag
- flag_v  out  1  overflow flag
- flag_n  out  1  negative flag

Behaviour:
- Opcode map: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, LW 1000, SW 1001, LLB 1010, LHB 1011, B 1100, BR 1101, PCS 1110, HLT 1111.
- Reset (rst_n=0, asynchronous, takes effect immediately, independent of clk):
  - All outputs 0, including flags Z=V=N=0.
  - Reset mid-stall or mid-flush discards everything; first edge after release behaves as a normal load.
- Per-edge priority: reset > flush > stall > load.
- Load (flush=0, stall=0):
  - All mem_* take ex_* with 1-cycle latency.
  - mem_valid = ex_valid.
  - If ex_valid=0: mem_reg_wr, mem_mem_rd, mem_mem_wr and mem_halt are forced 0 regardless of inputs. Data fields are still captured.
- Stall (flush=0, stall=1): every mem_* output and all flags hold their values. No flag update.
- Flush (flush=1, stall ignored):
  - All mem_* outputs cleared to 0 (bubble).
  - Flags hold; a squashed instruction never updates flags.
- Flag update occurs only on a load edge with ex_valid=1:
  - ADD, SUB: Z = (ex_result == 0); V = ex_ovfl; N = ex_result[DATA_W-1].
  - XOR, SLL, SRA, ROR: Z = (ex_result == 0); V and N unchanged.
  - All other opcodes: no flag change; ex_ovfl ignored.
- Flags are registered.
  - An instruction's flag effect is visible the cycle after its load edge.
  - A branch reading flags in the same cycle as a flag-setting instruction in EX sees the old flags; the hazard unit must stall it.
- Back-to-back flag setters: each load edge applies its own rule.
  - Example: ADD then SLL leaves V and N from the ADD and Z from the SLL.
- mem_halt is not sticky; it is a plain registered copy. Upstream halt holding is out of scope.
- No combinational path from any input to any output.

Test Plan:
- Reset:
  - Drive all inputs nonzero, assert rst_n=0 between clock edges.
  - All outputs read 0 immediately, without waiting for a clock edge.
- ADD load:
  - ex_valid=1, opcode 0000, result 0x8000, ovfl=1, rd=3, reg_wr=1.
  - Next cycle: mem_result=0x8000, mem_rd=3, mem_reg_wr=1, flags N=1, V=1, Z=0.
- Z-only update after that ADD:
  - Load SLL (0100) with result 0x0000.
  - Next cycle: Z=1, V=1, N=1 (unchanged).
  - Then LW (1000) with result 0 and ovfl=1: flags unchanged.
- Stall hold:
  - Hold stall=1 for 3 cycles while presenting SUB with result 0x0000.
  - Outputs and flags are frozen for all 3 cycles.
  - On release, the SUB loads: Z=1, V=ex_ovfl, N=0.
- Flush precedence:
  - flush=1 and stall=1 together with a valid ADD (result 0, reg_wr=1, mem_wr=1).
  - Next cycle: all mem_* = 0, flags unchanged.
- Bubble gating:
  - ex_valid=0 with reg_wr=1, mem_wr=1, halt=1, opcode 0000, result 0.
  - Next cycle: mem_valid=0, mem_reg_wr=mem_mem_wr=mem_halt=0, flags unchanged.
